cordic_gain_comp: RTL and testbench

Downstream stage of the iterative CORDIC core. It captures the core's final x/y/z result and removes the CORDIC gain from x and y with one shared fixed-point multiplier over two cycles. z passes through unscaled. It returns a saturated result behind a valid/ready handshake for the consumer.

---
 rtl/cordic_gain_comp_pkg.sv | 42 ++++
 rtl/cordic_gain_comp_if.sv | 33 +++
 rtl/cordic_gain_comp_fixed_scale_sat.sv | 44 ++++
 rtl/cordic_gain_comp.sv | 128 ++++++++++++
 tb/tb_cordic_gain_comp.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cordic_gain_comp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Purpose  : Shared encodings, FSM states and gain constants for the CORDIC
//            gain-compensation stage.
// Revision : 1.0
// ============================================================================
package cordic_pkg;

    localparam logic [1:0] CS_CIRCULAR   = 2'b00;
    localparam logic [1:0] CS_LINEAR     = 2'b01;
    localparam logic [1:0] CS_HYPERBOLIC = 2'b10;
    localparam logic [1:0] CS_RESERVED   = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCALE_X = 2'd1,
        SCALE_Y = 2'd2,
        OUT     = 2'd3
    } state_t;

    // 1/K and 1/K' held at Q30 so any narrower fraction can be rounded from them
    localparam int          C_GAIN_Q       = 30;
    localparam logic [63:0] C_INV_K_CIRC   = 64'd652032875;
    localparam logic [63:0] C_INV_K_HYP    = 64'd1296540104;
    localparam logic [63:0] C_UNITY        = 64'd1073741824;

    // Valid for 1 <= dec_bits <= 29; result is round-to-nearest of the gain.
    function automatic logic [31:0] gain_const(input logic [1:0] cs, input int dec_bits);
        logic [63:0] q;
        logic [63:0] r;
        case (cs)
            CS_CIRCULAR:   q = C_INV_K_CIRC;
            CS_HYPERBOLIC: q = C_INV_K_HYP;
            default:       q = C_UNITY;
        endcase
        r = (q + (64'd1 << (C_GAIN_Q - 1 - dec_bits))) >> (C_GAIN_Q - dec_bits);
        return r[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_gain_comp_if.sv
`default_nettype none
// ============================================================================
// Module   : cordic_gain_comp_if
// Purpose  : Core-result input and compensated-result output handshakes.
// Revision : 1.0
// ============================================================================
interface cordic_gain_comp_if #(
    parameter int BIT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] x_in;
    logic [BIT_WIDTH-1:0] y_in;
    logic [BIT_WIDTH-1:0] z_in;
    logic [1:0]           coordinate_system_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] x_out;
    logic [BIT_WIDTH-1:0] y_out;
    logic [BIT_WIDTH-1:0] z_out;
    logic                 sat_flag;

    modport master (
        output in_valid, x_in, y_in, z_in, coordinate_system_in, out_ready,
        input  in_ready, out_valid, x_out, y_out, z_out, sat_flag
    );

    modport slave (
        input  in_valid, x_in, y_in, z_in, coordinate_system_in, out_ready,
        output in_ready, out_valid, x_out, y_out, z_out, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/cordic_gain_comp_fixed_scale_sat.sv
`default_nettype none
// ============================================================================
// Module   : fixed_scale_sat
// Purpose  : Signed x unsigned fixed-point multiply, round-half-up, saturate.
// Revision : 1.0
// ============================================================================
module fixed_scale_sat #(
    parameter int BIT_WIDTH         = 8,
    parameter int DECIMAL_BIT_WIDTH = 5,
    parameter int GAIN_WIDTH        = 7
) (
    input  wire logic [BIT_WIDTH-1:0]  value,
    input  wire logic [GAIN_WIDTH-1:0] gain,
    output logic      [BIT_WIDTH-1:0]  scaled,
    output logic                       sat
);
    localparam int PW = 2 * BIT_WIDTH;
    localparam logic signed [PW-1:0] C_ROUND = PW'(64'd1 << (DECIMAL_BIT_WIDTH - 1));
    localparam logic signed [PW-1:0] C_MAX   = PW'((64'd1 << (BIT_WIDTH - 1)) - 64'd1);
    localparam logic signed [PW-1:0] C_MIN   = ~C_MAX;

    logic signed [PW-1:0] w_value_ext;
    logic signed [PW-1:0] w_gain_ext;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_round;

    assign w_value_ext = {{BIT_WIDTH{value[BIT_WIDTH-1]}}, value};
    assign w_gain_ext  = {{(PW-GAIN_WIDTH){1'b0}}, gain};
    assign w_prod      = w_value_ext * w_gain_ext;
    assign w_round     = (w_prod + C_ROUND) >>> DECIMAL_BIT_WIDTH;

    always_comb begin
        sat    = 1'b0;
        scaled = w_round[BIT_WIDTH-1:0];
        if (w_round > C_MAX) begin
            sat    = 1'b1;
            scaled = C_MAX[BIT_WIDTH-1:0];
        end else if (w_round < C_MIN) begin
            sat    = 1'b1;
            scaled = C_MIN[BIT_WIDTH-1:0];
        end
    end
endmodule
`default_nettype wire

// File: rtl/cordic_gain_comp.sv
`default_nettype none
// ============================================================================
// Module   : cordic_gain_comp
// Purpose  : Removes CORDIC gain from x/y with one time-shared multiplier.
// Revision : 1.0
// ============================================================================
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int WHOLE_BIT_WIDTH   = 3,
    parameter int DECIMAL_BIT_WIDTH = 5,
    parameter int BIT_WIDTH         = WHOLE_BIT_WIDTH + DECIMAL_BIT_WIDTH
) (
    input wire logic           clk,
    input wire logic           rst,
    cordic_gain_comp_if.slave  bus
);
    // Largest gain (~1.21) needs one integer bit plus headroom
    localparam int GAIN_WIDTH = DECIMAL_BIT_WIDTH + 2;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_in_ready;
    logic                   w_out_valid;

    logic [BIT_WIDTH-1:0]   r_x;
    logic [BIT_WIDTH-1:0]   r_y;
    logic [BIT_WIDTH-1:0]   r_z;
    logic [1:0]             r_cs;
    logic [BIT_WIDTH-1:0]   r_x_out;
    logic [BIT_WIDTH-1:0]   r_y_out;
    logic [BIT_WIDTH-1:0]   r_z_out;
    logic                   r_sat;

    logic [BIT_WIDTH-1:0]   w_operand;
    logic [GAIN_WIDTH-1:0]  w_gain;
    logic [BIT_WIDTH-1:0]   w_scaled;
    logic                   w_sat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next_state = SCALE_X;
                end
            end
            SCALE_X: w_next_state = SCALE_Y;
            SCALE_Y: w_next_state = OUT;
            OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_operand = (r_state == SCALE_Y) ? r_y : r_x;
    assign w_gain    = GAIN_WIDTH'(gain_const(r_cs, DECIMAL_BIT_WIDTH));

    fixed_scale_sat #(
        .BIT_WIDTH         (BIT_WIDTH),
        .DECIMAL_BIT_WIDTH (DECIMAL_BIT_WIDTH),
        .GAIN_WIDTH        (GAIN_WIDTH)
    ) u_scale (
        .value  (w_operand),
        .gain   (w_gain),
        .scaled (w_scaled),
        .sat    (w_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_cs    <= '0;
            r_x_out <= '0;
            r_y_out <= '0;
            r_z_out <= '0;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_x   <= bus.x_in;
                        r_y   <= bus.y_in;
                        r_z   <= bus.z_in;
                        r_cs  <= bus.coordinate_system_in;
                        r_sat <= 1'b0;
                    end
                end
                SCALE_X: begin
                    r_x_out <= w_scaled;
                    r_sat   <= w_sat;
                end
                SCALE_Y: begin
                    r_y_out <= w_scaled;
                    r_sat   <= r_sat | w_sat;
                    r_z_out <= r_z;
                end
                default: ;
            endcase
        end
    end

    // Ready is withheld while reset is held so nothing is offered mid-reset
    assign bus.in_ready  = w_in_ready & rst;
    assign bus.out_valid = w_out_valid;
    assign bus.x_out     = r_x_out;
    assign bus.y_out     = r_y_out;
    assign bus.z_out     = r_z_out;
    assign bus.sat_flag  = r_sat;
endmodule
`default_nettype wire

// File: tb/tb_cordic_gain_comp.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_gain_comp
// Purpose  : Directed self-checking bench for cordic_gain_comp.
// Revision : 1.0
// ============================================================================
module tb_cordic_gain_comp;
    logic clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;

    cordic_gain_comp_if #(.BIT_WIDTH(8)) bus ();

    cordic_gain_comp #(
        .WHOLE_BIT_WIDTH   (3),
        .DECIMAL_BIT_WIDTH (5)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_value("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_one(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] z, input logic [1:0] cs,
                           input logic [7:0] ex, input logic [7:0] ey, input logic es);
        wait_ready();
        bus.x_in = x; bus.y_in = y; bus.z_in = z;
        bus.coordinate_system_in = cs;
        bus.in_valid = 1'b1;
        tick();
        // disturb inputs after accept; must not affect the in-flight result
        bus.in_valid = 1'b0;
        bus.x_in = 8'h55; bus.y_in = 8'h66; bus.z_in = 8'h77;
        bus.coordinate_system_in = ~cs;
        check_value({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        check_value({tag, "_valid_early"}, 32'(bus.out_valid), 32'd0);
        tick();
        check_value({tag, "_valid_early2"}, 32'(bus.out_valid), 32'd0);
        tick();
        check_value({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check_value({tag, "_x"}, 32'(bus.x_out), 32'(ex));
        check_value({tag, "_y"}, 32'(bus.y_out), 32'(ey));
        check_value({tag, "_z"}, 32'(bus.z_out), 32'(z));
        check_value({tag, "_sat"}, 32'(bus.sat_flag), 32'(es));
        bus.out_ready = 1'b1;
        tick();
        check_value({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    logic [7:0] b2b_x   [5] = '{8'h20, 8'h10, 8'h08, 8'hF0, 8'h60};
    logic [7:0] b2b_exp [5] = '{8'h13, 8'h0A, 8'h05, 8'hF7, 8'h39};

    initial begin
        int k;
        int got;
        int last;
        n_compared   = 0;
        n_mismatched = 0;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_in = '0; bus.y_in = '0; bus.z_in = '0;
        bus.coordinate_system_in = 2'b00;

        tick();
        check_value("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check_value("reset_outputs", 32'({bus.x_out, bus.y_out, bus.z_out, 7'd0, bus.sat_flag}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_value("reset_in_ready", 32'(bus.in_ready), 32'd1);

        run_one("circ", 8'h20, 8'hE0, 8'h05, 2'b00, 8'h13, 8'hED, 1'b0);
        run_one("hyp",  8'h40, 8'h7F, 8'h7A, 2'b10, 8'h4E, 8'h7F, 1'b1);
        run_one("hyp_neg", 8'hC0, 8'h80, 8'h01, 2'b10, 8'hB2, 8'h80, 1'b1);
        run_one("lin",  8'hA3, 8'h11, 8'h22, 2'b01, 8'hA3, 8'h11, 1'b0);
        run_one("rsv",  8'hA3, 8'h11, 8'h23, 2'b11, 8'hA3, 8'h11, 1'b0);

        // reset while in SCALE_Y
        wait_ready();
        bus.x_in = 8'h20; bus.y_in = 8'h20; bus.z_in = 8'h09;
        bus.coordinate_system_in = 2'b00;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        #1;
        rst = 1'b0;
        #1;
        check_value("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        check_value("rst_mid_outputs", 32'({bus.x_out, bus.y_out, bus.z_out, 7'd0, bus.sat_flag}), 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_value("rst_release_ready", 32'(bus.in_ready), 32'd1);
        check_value("rst_release_valid", 32'(bus.out_valid), 32'd0);
        run_one("after_rst", 8'h10, 8'h08, 8'h0C, 2'b00, 8'h0A, 8'h05, 1'b0);

        // backpressure with in_valid held and inputs changing
        wait_ready();
        bus.x_in = 8'h10; bus.y_in = 8'h08; bus.z_in = 8'h33;
        bus.coordinate_system_in = 2'b00;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.x_in = 8'h01;
        tick();
        bus.x_in = 8'h02;
        tick();
        for (int c = 0; c < 10; c++) begin
            bus.x_in = 8'(c * 7); bus.y_in = 8'(c * 3); bus.z_in = 8'(c);
            tick();
            check_value("bp_hold", 32'({bus.out_valid, bus.in_ready, bus.x_out, bus.y_out, bus.z_out}),
                        {8'd0, 1'b1, 1'b0, 8'h0A, 8'h05, 8'h33} >> 0);
        end
        bus.x_in = 8'h60; bus.y_in = 8'h20; bus.z_in = 8'h44;
        bus.out_ready = 1'b1;
        tick();
        check_value("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check_value("bp_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check_value("bp_next_valid", 32'(bus.out_valid), 32'd1);
        check_value("bp_next_x", 32'(bus.x_out), 32'h39);
        check_value("bp_next_y", 32'(bus.y_out), 32'h13);
        check_value("bp_next_z", 32'(bus.z_out), 32'h44);
        bus.out_ready = 1'b1;
        tick();

        // back-to-back stream
        k = 0; got = 0; last = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            if (bus.out_valid === 1'b1) begin
                check_value("b2b_x", 32'(bus.x_out), 32'(b2b_exp[got]));
                check_value("b2b_y", 32'(bus.y_out), 32'h26);
                check_value("b2b_z", 32'(bus.z_out), 32'(got + 1));
                if (got > 0) check_value("b2b_spacing", 32'(cyc - last), 32'd4);
                last = cyc;
                got++;
            end
            if (bus.in_ready === 1'b1) begin
                if (k < 5) begin
                    bus.x_in = b2b_x[k]; bus.y_in = 8'h40; bus.z_in = 8'(k + 1);
                    bus.coordinate_system_in = 2'b00;
                    bus.in_valid = 1'b1;
                    k++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            tick();
        end
        bus.in_valid = 1'b0;
        check_value("b2b_count", 32'(got), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
`default_nettype wire
